hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline hazard unit for the 5-stage (F/D/E/M/W) core. It keeps the existing M/W forwarding and load-use stall logic, extended to `NREAD` source operands. It adds a registered per-register scoreboard that tracks outstanding long-latency writes (mul/div, uncached AXI loads) which retire out-of-band through a completion port, and it stalls Decode on RAW, WAW and capacity hazards against those writes. It sits beside the datapath, and all stage stall/flush and forward-select signals come from it.

---
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: M/W forwarding, load-use stall, and a
// per-register scoreboard for long-latency writes that retire via CompValid/CompRd.
module hazard_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned REGW    = 5,
  parameter int unsigned NREAD   = 2,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNTW    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*REGW-1:0]   RsD,
  input  logic [REGW-1:0]         RdD,
  input  logic                    RegWriteD,
  input  logic                    LongOpD,
  input  logic [NREAD*REGW-1:0]   RsE,
  input  logic [REGW-1:0]         RdE,
  input  logic                    RegWriteE,
  input  logic                    LongOpE,
  input  logic                    ResultSrcE0,
  input  logic                    PCSrcE,
  input  logic [REGW-1:0]         RdM,
  input  logic                    RegWriteM,
  input  logic [REGW-1:0]         RdW,
  input  logic                    RegWriteW,
  input  logic                    CompValid,
  input  logic [REGW-1:0]         CompRd,
  input  logic                    Stall,
  output logic                    StallF,
  output logic                    StallD,
  output logic                    StallE,
  output logic                    StallM,
  output logic                    StallW,
  output logic                    FlushD,
  output logic                    FlushE,
  output logic [2*NREAD-1:0]      ForwardE,
  output logic [NREG-1:0]         Pending,
  output logic [CNTW-1:0]         OutCnt,
  output logic                    SbErr
);

  logic            srcMatchE, rawHaz, loadHaz, longE, longHaz, capHaz, wawHaz, sbHaz, hazD;
  logic            issue, full, validClr, badComp, issueOk, dropErr;
  logic [CNTW:0]   occ;
  logic [NREG-1:0] pendNext;
  logic [CNTW-1:0] cntNext;
  logic            errNext;

  always_comb begin
    ForwardE  = '0;
    srcMatchE = 1'b0;
    rawHaz    = 1'b0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      if (RegWriteM && RsE[i*REGW +: REGW] == RdM && RsE[i*REGW +: REGW] != '0)
        ForwardE[2*i +: 2] = 2'b10;
      else if (RegWriteW && RsE[i*REGW +: REGW] == RdW && RsE[i*REGW +: REGW] != '0)
        ForwardE[2*i +: 2] = 2'b01;
      if (RsD[i*REGW +: REGW] == RdE)
        srcMatchE = 1'b1;
      if (Pending[RsD[i*REGW +: REGW]])
        rawHaz = 1'b1;
    end
  end

  assign loadHaz = ResultSrcE0 & (RdE != '0) & srcMatchE;
  assign longE   = LongOpE & RegWriteE & (RdE != '0);
  assign longHaz = longE & srcMatchE;
  assign wawHaz  = RegWriteD & Pending[RdD];
  assign occ     = {1'b0, OutCnt} + {{CNTW{1'b0}}, longE};
  assign capHaz  = LongOpD & (occ >= (CNTW+1)'(MAX_OUT));
  assign sbHaz   = rawHaz | wawHaz | capHaz;
  assign hazD    = loadHaz | longHaz | sbHaz;

  assign StallF = hazD | Stall;
  assign StallD = hazD | Stall;
  assign StallE = Stall;
  assign StallM = Stall;
  assign StallW = Stall;
  assign FlushD = PCSrcE & ~Stall;
  assign FlushE = (PCSrcE | hazD) & ~Stall;

  assign issue    = longE & ~Stall;
  assign full     = (OutCnt == CNTW'(MAX_OUT));
  assign validClr = CompValid & (CompRd != '0) & Pending[CompRd];
  assign badComp  = CompValid & (CompRd != '0) & ~Pending[CompRd];
  // A completion in the same cycle frees a slot, so a full scoreboard may still accept the issue.
  assign issueOk  = issue & (~full | validClr);
  assign dropErr  = issue & full & ~validClr;

  always_comb begin
    pendNext = Pending;
    if (validClr) pendNext[CompRd] = 1'b0;
    if (issueOk)  pendNext[RdE]    = 1'b1;
    pendNext[0] = 1'b0;

    cntNext = OutCnt;
    if (issueOk && !validClr)
      cntNext = OutCnt + 1'b1;
    else if (!issueOk && validClr && OutCnt != '0)
      cntNext = OutCnt - 1'b1;

    errNext = SbErr | badComp | dropErr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Pending <= '0;
      OutCnt  <= '0;
      SbErr   <= 1'b0;
    end else begin
      Pending <= pendNext;
      OutCnt  <= cntNext;
      SbErr   <= errNext;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: expectations are queued as stimulus
// is driven and popped when the DUT outputs are sampled on the falling edge.
module tb_hazard_scoreboard;
  localparam int unsigned NREG = 32, REGW = 5, NREAD = 2, MAX_OUT = 4, CNTW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [NREAD*REGW-1:0] RsD, RsE;
  logic [REGW-1:0] RdD, RdE, RdM, RdW, CompRd;
  logic RegWriteD, LongOpD, RegWriteE, LongOpE, ResultSrcE0, PCSrcE;
  logic RegWriteM, RegWriteW, CompValid, Stall;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [2*NREAD-1:0] ForwardE;
  logic [NREG-1:0] Pending;
  logic [CNTW-1:0] OutCnt;
  logic SbErr;
  logic [6:0] ctl;

  int errors = 0;
  int checks = 0;
  logic [31:0] expQ[$];

  hazard_scoreboard #(.NREG(NREG), .REGW(REGW), .NREAD(NREAD), .MAX_OUT(MAX_OUT), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RdD(RdD), .RegWriteD(RegWriteD), .LongOpD(LongOpD),
    .RsE(RsE), .RdE(RdE), .RegWriteE(RegWriteE), .LongOpE(LongOpE), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .CompValid(CompValid), .CompRd(CompRd), .Stall(Stall),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardE(ForwardE), .Pending(Pending),
    .OutCnt(OutCnt), .SbErr(SbErr)
  );

  assign ctl = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};

  always #5 clk = ~clk;

  task automatic idle();
    RsD = '0; RdD = '0; RegWriteD = 0; LongOpD = 0;
    RsE = '0; RdE = '0; RegWriteE = 0; LongOpE = 0; ResultSrcE0 = 0; PCSrcE = 0;
    RdM = '0; RegWriteM = 0; RdW = '0; RegWriteW = 0;
    CompValid = 0; CompRd = '0; Stall = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issueLong(input logic [REGW-1:0] rd);
    tick(); idle();
    LongOpE = 1; RegWriteE = 1; RdE = rd;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    idle();
    rst_n = 1; #1 rst_n = 0; #2;
    expQ.push_back(32'h0); expQ.push_back(32'h0); expQ.push_back(32'h0); expQ.push_back(32'h0);
    e = expQ.pop_front(); checks++;
    if (Pending !== e) begin errors++; $display("FAIL reset_pending got=%h exp=%h", Pending, e); end
    e = expQ.pop_front(); checks++;
    if (OutCnt !== e[2:0]) begin errors++; $display("FAIL reset_outcnt got=%0d exp=%0d", OutCnt, e[2:0]); end
    e = expQ.pop_front(); checks++;
    if (SbErr !== e[0]) begin errors++; $display("FAIL reset_sberr got=%b exp=%b", SbErr, e[0]); end
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, e[6:0]); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_forward();
    logic [31:0] e;
    logic [REGW-1:0] rs0[4] = '{5'd5, 5'd0, 5'd5, 5'd5};
    logic [REGW-1:0] rs1[4] = '{5'd5, 5'd0, 5'd5, 5'd3};
    logic            wm[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0]      fw[4]  = '{4'b1010, 4'b0000, 4'b0101, 4'b0110};
    for (int k = 0; k < 4; k++) begin
      tick(); idle();
      RsE = {rs1[k], rs0[k]};
      RdM = (k == 1) ? 5'd0 : 5'd5; RegWriteM = wm[k];
      RdW = (k == 3) ? 5'd3 : 5'd5; RegWriteW = 1;
      expQ.push_back({28'h0, fw[k]});
      @(negedge clk);
      e = expQ.pop_front(); checks++;
      if (ForwardE !== e[3:0]) begin errors++; $display("FAIL forward_%0d got=%b exp=%b", k, ForwardE, e[3:0]); end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] e;
    tick(); idle();
    ResultSrcE0 = 1; RegWriteE = 1; RdE = 5'd7; RsD = {5'd7, 5'd1};
    expQ.push_back({25'h0, 7'b1100001});
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL load_use_stall got=%b exp=%b", ctl, e[6:0]); end
    tick(); idle();
    RsD = {5'd7, 5'd1};
    expQ.push_back(32'h0);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL load_use_release got=%b exp=%b", ctl, e[6:0]); end
    tick(); idle();
    ResultSrcE0 = 1; RegWriteE = 1; RdE = 5'd0; RsD = {5'd0, 5'd1};
    expQ.push_back(32'h0);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL load_x0_nostall got=%b exp=%b", ctl, e[6:0]); end
  endtask

  task automatic test_long_raw();
    logic [31:0] e;
    issueLong(5'd9); RsD = {5'd0, 5'd9};
    expQ.push_back({25'h0, 7'b1100001});
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL long_haz got=%b exp=%b", ctl, e[6:0]); end
    tick(); idle(); RsD = {5'd0, 5'd9};
    expQ.push_back({25'h0, 7'b1100001}); expQ.push_back(32'h200); expQ.push_back(32'd1);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL pending_haz got=%b exp=%b", ctl, e[6:0]); end
    e = expQ.pop_front(); checks++;
    if (Pending !== e) begin errors++; $display("FAIL pending_x9 got=%h exp=%h", Pending, e); end
    e = expQ.pop_front(); checks++;
    if (OutCnt !== e[2:0]) begin errors++; $display("FAIL outcnt_one got=%0d exp=%0d", OutCnt, e[2:0]); end
    tick(); idle(); RsD = {5'd0, 5'd9}; CompValid = 1; CompRd = 5'd9;
    expQ.push_back({25'h0, 7'b1100001});
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL comp_cycle_stall got=%b exp=%b", ctl, e[6:0]); end
    tick(); idle(); RsD = {5'd0, 5'd9};
    expQ.push_back(32'h0); expQ.push_back(32'h0);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL comp_release got=%b exp=%b", ctl, e[6:0]); end
    e = expQ.pop_front(); checks++;
    if (OutCnt !== e[2:0]) begin errors++; $display("FAIL outcnt_zero got=%0d exp=%0d", OutCnt, e[2:0]); end
  endtask

  task automatic test_capacity();
    logic [31:0] e;
    issueLong(5'd1);
    issueLong(5'd2);
    issueLong(5'd3); LongOpD = 1;
    expQ.push_back(32'h0);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL cap_below got=%b exp=%b", ctl, e[6:0]); end
    issueLong(5'd4); LongOpD = 1;
    expQ.push_back({25'h0, 7'b1100001});
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL cap_with_longE got=%b exp=%b", ctl, e[6:0]); end
    tick(); idle(); LongOpD = 1; RegWriteD = 1; RdD = 5'd20;
    expQ.push_back({25'h0, 7'b1100001}); expQ.push_back(32'h1E);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL cap_full got=%b exp=%b", ctl, e[6:0]); end
    e = expQ.pop_front(); checks++;
    if (Pending !== e) begin errors++; $display("FAIL cap_pending got=%h exp=%h", Pending, e); end
    tick(); idle(); RegWriteD = 1; RdD = 5'd3;
    expQ.push_back({25'h0, 7'b1100001});
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL waw got=%b exp=%b", ctl, e[6:0]); end
    tick(); idle(); RegWriteD = 1; RdD = 5'd20;
    expQ.push_back(32'h0);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL no_waw got=%b exp=%b", ctl, e[6:0]); end
    issueLong(5'd5); CompValid = 1; CompRd = 5'd2;
    issueLong(5'd1); CompValid = 1; CompRd = 5'd1;
    expQ.push_back(32'h3A); expQ.push_back(32'd4); expQ.push_back(32'd0);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (Pending !== e) begin errors++; $display("FAIL swap_pending got=%h exp=%h", Pending, e); end
    e = expQ.pop_front(); checks++;
    if (OutCnt !== e[2:0]) begin errors++; $display("FAIL swap_outcnt got=%0d exp=%0d", OutCnt, e[2:0]); end
    e = expQ.pop_front(); checks++;
    if (SbErr !== e[0]) begin errors++; $display("FAIL swap_sberr got=%b exp=%b", SbErr, e[0]); end
    tick(); idle();
    expQ.push_back(32'h3A); expQ.push_back(32'd4);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (Pending !== e) begin errors++; $display("FAIL setwins_pending got=%h exp=%h", Pending, e); end
    e = expQ.pop_front(); checks++;
    if (OutCnt !== e[2:0]) begin errors++; $display("FAIL setwins_outcnt got=%0d exp=%0d", OutCnt, e[2:0]); end
    for (int k = 0; k < 4; k++) begin
      tick(); idle(); CompValid = 1;
      CompRd = (k == 0) ? 5'd1 : (k == 1) ? 5'd3 : (k == 2) ? 5'd4 : 5'd5;
    end
    tick(); idle();
    expQ.push_back(32'h0); expQ.push_back(32'd0); expQ.push_back(32'd0);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (Pending !== e) begin errors++; $display("FAIL drain_pending got=%h exp=%h", Pending, e); end
    e = expQ.pop_front(); checks++;
    if (OutCnt !== e[2:0]) begin errors++; $display("FAIL drain_outcnt got=%0d exp=%0d", OutCnt, e[2:0]); end
    e = expQ.pop_front(); checks++;
    if (SbErr !== e[0]) begin errors++; $display("FAIL drain_sberr got=%b exp=%b", SbErr, e[0]); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] e;
    for (int k = 0; k < 3; k++) begin
      tick(); idle(); Stall = 1; PCSrcE = 1; LongOpE = 1; RegWriteE = 1; RdE = 5'd10;
      expQ.push_back({25'h0, 7'b1111100});
      @(negedge clk);
      e = expQ.pop_front(); checks++;
      if (ctl !== e[6:0]) begin errors++; $display("FAIL stall_hold_%0d got=%b exp=%b", k, ctl, e[6:0]); end
    end
    tick(); idle(); PCSrcE = 1;
    expQ.push_back({25'h0, 7'b0000011}); expQ.push_back(32'd0);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (ctl !== e[6:0]) begin errors++; $display("FAIL flush_release got=%b exp=%b", ctl, e[6:0]); end
    e = expQ.pop_front(); checks++;
    if (OutCnt !== e[2:0]) begin errors++; $display("FAIL stalled_no_issue got=%0d exp=%0d", OutCnt, e[2:0]); end
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    issueLong(5'd1); issueLong(5'd2); issueLong(5'd3); issueLong(5'd4);
    issueLong(5'd5);
    tick(); idle();
    expQ.push_back(32'd4); expQ.push_back(32'h1E); expQ.push_back(32'd1);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (OutCnt !== e[2:0]) begin errors++; $display("FAIL ovf_outcnt got=%0d exp=%0d", OutCnt, e[2:0]); end
    e = expQ.pop_front(); checks++;
    if (Pending !== e) begin errors++; $display("FAIL ovf_pending got=%h exp=%h", Pending, e); end
    e = expQ.pop_front(); checks++;
    if (SbErr !== e[0]) begin errors++; $display("FAIL ovf_sberr got=%b exp=%b", SbErr, e[0]); end
    tick(); #2 rst_n = 0; #1;
    expQ.push_back(32'h0); expQ.push_back(32'd0); expQ.push_back(32'd0);
    e = expQ.pop_front(); checks++;
    if (Pending !== e) begin errors++; $display("FAIL async_rst_pending got=%h exp=%h", Pending, e); end
    e = expQ.pop_front(); checks++;
    if (OutCnt !== e[2:0]) begin errors++; $display("FAIL async_rst_outcnt got=%0d exp=%0d", OutCnt, e[2:0]); end
    e = expQ.pop_front(); checks++;
    if (SbErr !== e[0]) begin errors++; $display("FAIL async_rst_sberr got=%b exp=%b", SbErr, e[0]); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_bad_completion();
    logic [31:0] e;
    tick(); idle(); CompValid = 1; CompRd = 5'd0;
    tick(); idle();
    expQ.push_back(32'd0);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (SbErr !== e[0]) begin errors++; $display("FAIL comp_x0_noerr got=%b exp=%b", SbErr, e[0]); end
    CompValid = 1; CompRd = 5'd12;
    tick(); idle();
    expQ.push_back(32'd1); expQ.push_back(32'd0);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (SbErr !== e[0]) begin errors++; $display("FAIL bad_comp_err got=%b exp=%b", SbErr, e[0]); end
    e = expQ.pop_front(); checks++;
    if (OutCnt !== e[2:0]) begin errors++; $display("FAIL bad_comp_outcnt got=%0d exp=%0d", OutCnt, e[2:0]); end
    repeat (2) tick();
    expQ.push_back(32'd1);
    @(negedge clk);
    e = expQ.pop_front(); checks++;
    if (SbErr !== e[0]) begin errors++; $display("FAIL sberr_sticky got=%b exp=%b", SbErr, e[0]); end
    tick(); #2 rst_n = 0; #1;
    expQ.push_back(32'd0);
    e = expQ.pop_front(); checks++;
    if (SbErr !== e[0]) begin errors++; $display("FAIL sberr_reset got=%b exp=%b", SbErr, e[0]); end
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_long_raw();
    test_capacity();
    test_stall_flush();
    test_overflow();
    test_bad_completion();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
